// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl
// Bit-serial sequencer wrapped around a 1-bit add/subtract process unit.
// A start in IDLE captures the operands and op. Each RUN cycle presents one bit
// pair (LSB first) to the unit and feeds the unit's carry back into the next bit.
// The sum bits are shifted into a parallel result. Flags are registered with the
// final bit, and done pulses for one cycle.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   start, op        request (sampled in IDLE only); 0 = A+B, 1 = A-B
//   op_a, op_b       WIDTH-bit operands, sampled with start
//   busy, done       high in RUN/DONE; one-cycle completion pulse
//   result           assembled result, held until the next accepted start
//   carry_out        final carry (for SUB, 1 = no borrow)
//   zero, overflow   result == 0; signed overflow
//   pu_a/pu_b/pu_sel/pu_cin  drives to the process unit (0 outside RUN)
//   pu_r/pu_cout     combinational returns from the process unit
module serial_alu_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             overflow,
  output logic             pu_a,
  output logic             pu_b,
  output logic             pu_sel,
  output logic             pu_cin,
  input  logic             pu_r,
  input  logic             pu_cout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic             op_r;
  logic             carry_r;
  logic [CW-1:0]    bit_cnt_r;
  logic [WIDTH-1:0] result_nxt_s;
  logic             last_bit_s;

  assign last_bit_s   = (bit_cnt_r == CNT_LAST);
  // Result after absorbing the bit currently produced by the process unit.
  assign result_nxt_s = {pu_r, result[WIDTH-1:1]};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_bit_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Process-unit drives; must be combinational so pu_r/pu_cout settle within the cycle.
  always_comb begin
    pu_a   = 1'b0;
    pu_b   = 1'b0;
    pu_sel = 1'b0;
    pu_cin = 1'b0;
    if (state_r == ST_RUN) begin
      pu_a   = a_sr_r[0];
      pu_b   = b_sr_r[0];
      pu_sel = op_r;
      pu_cin = carry_r;
    end else begin
      pu_a   = 1'b0;
      pu_b   = 1'b0;
      pu_sel = 1'b0;
      pu_cin = 1'b0;
    end
  end

  // Registered status outputs, decoded from the upcoming state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nxt_s != ST_IDLE);
      done <= (state_nxt_s == ST_DONE);
    end
  end

  // Operand capture, serial shifting, carry feedback and flag capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr_r    <= {WIDTH{1'b0}};
      b_sr_r    <= {WIDTH{1'b0}};
      op_r      <= 1'b0;
      carry_r   <= 1'b0;
      bit_cnt_r <= {CW{1'b0}};
      result    <= {WIDTH{1'b0}};
      carry_out <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            a_sr_r    <= op_a;
            b_sr_r    <= op_b;
            op_r      <= op;
            // Carry-in of op supplies the +1 of the two's-complement subtract.
            carry_r   <= op;
            bit_cnt_r <= {CW{1'b0}};
          end
        end
        ST_RUN: begin
          a_sr_r    <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r    <= {1'b0, b_sr_r[WIDTH-1:1]};
          result    <= result_nxt_s;
          carry_r   <= pu_cout;
          bit_cnt_r <= bit_cnt_r + CNT_ONE;
          if (last_bit_s) begin
            carry_out <= pu_cout;
            // carry_r still holds the carry into the MSB here.
            overflow  <= carry_r ^ pu_cout;
            zero      <= (result_nxt_s == {WIDTH{1'b0}});
          end
        end
        ST_DONE: begin
          bit_cnt_r <= {CW{1'b0}};
        end
        default: begin
          bit_cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule
